cfg_loader: RTL

CFG_LOADER -- requirements
Module: cfg_loader

---
 rtl/cfg_pkg.sv | 23 ++
 rtl/cfg_crc8.sv | 23 ++
 rtl/cfg_loader.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/cfg_pkg.sv
// Shared types and constants for the configuration-chain loader:
// FSM state encoding and the bit-serial CRC-8 definition.
package cfg_pkg;

  localparam int CRC_W = 8;
  localparam logic [CRC_W-1:0] CRC_POLY = 8'h07;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_FINISH = 2'd3
  } cfg_state_e;

  // One MSB-first CRC step: feedback is the outgoing MSB xor the new bit.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc,
                                                input logic bit_in);
    logic fb;
    fb = crc[CRC_W-1] ^ bit_in;
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/cfg_crc8.sv
// Bit-serial CRC-8 accumulator with synchronous clear (priority) and enable.
module cfg_crc8
  import cfg_pkg::*;
(
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic             clr,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= crc_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/cfg_loader.sv
// Streams host words MSB-first into a serial configuration chain, then
// optionally recirculates the chain once and compares TX/RX CRC-8 signatures.
//
// Handshake: a word moves on a rising edge where wr_valid=1 and wr_ready=1;
// wr_valid/wr_data may change freely while wr_ready=0.
module cfg_loader
  import cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 48,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              start,
  input  logic              verify_en,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              config_en,
  output logic              config_data_out,
  input  logic              config_data_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        dbg_state
);

  localparam int N_WORDS   = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int LAST_BITS = ((CHAIN_LEN % WORD_W) == 0) ? WORD_W : (CHAIN_LEN % WORD_W);
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam int WCNT_W    = $clog2(N_WORDS + 1);
  localparam int BIDX_W    = $clog2(WORD_W + 1);

  cfg_state_e        state_q, state_d;
  logic [WORD_W-1:0] word_buf_q;
  logic [BIDX_W-1:0] bits_left_q;
  logic [WCNT_W-1:0] word_cnt_q;
  logic [CNT_W-1:0]  shift_cnt_q;
  logic              verify_q;
  logic              err_q;

  logic              start_ok;
  logic              in_load;
  logic              buf_full;
  logic              shift;
  logic              last_shift;
  logic              buf_drain;
  logic              accept;
  logic              tx_en;
  logic              rx_en;
  logic [CRC_W-1:0]  crc_tx;
  logic [CRC_W-1:0]  crc_rx;

  assign start_ok   = en && (state_q == ST_IDLE) && start;
  assign in_load    = (state_q == ST_LOAD);
  assign buf_full   = (bits_left_q != '0);
  assign shift      = en && config_en;
  assign last_shift = shift && (shift_cnt_q == CNT_W'(CHAIN_LEN - 1));
  assign buf_drain  = in_load && shift && (bits_left_q == BIDX_W'(1));

  // Refill in the same cycle the last buffered bit leaves, so words stream at full rate.
  assign wr_ready = en && in_load && (word_cnt_q < WCNT_W'(N_WORDS)) && (!buf_full || buf_drain);
  assign accept   = wr_valid && wr_ready;

  always_comb begin
    state_d         = state_q;
    config_en       = 1'b0;
    config_data_out = 1'b0;
    done            = 1'b0;
    tx_en           = 1'b0;
    rx_en           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        config_en       = buf_full;
        config_data_out = buf_full & word_buf_q[WORD_W-1];
        tx_en           = shift;
        if (last_shift) state_d = verify_q ? ST_VERIFY : ST_FINISH;
      end
      ST_VERIFY: begin
        // Recirculate so that a full pass leaves the chain unchanged.
        config_en       = 1'b1;
        config_data_out = config_data_in;
        rx_en           = shift;
        if (last_shift) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        done = en;
        if (en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      word_buf_q  <= '0;
      bits_left_q <= '0;
      word_cnt_q  <= '0;
      shift_cnt_q <= '0;
      verify_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        verify_q    <= verify_en;
        err_q       <= 1'b0;
        word_cnt_q  <= '0;
        shift_cnt_q <= '0;
        bits_left_q <= '0;
      end else begin
        if (shift && (state_q == ST_LOAD || state_q == ST_VERIFY)) begin
          shift_cnt_q <= last_shift ? '0 : shift_cnt_q + CNT_W'(1);
        end
        // A new word overrides the drain of the old word's final bit.
        if (accept) begin
          word_buf_q  <= wr_data;
          bits_left_q <= (word_cnt_q == WCNT_W'(N_WORDS - 1)) ? BIDX_W'(LAST_BITS)
                                                              : BIDX_W'(WORD_W);
          word_cnt_q  <= word_cnt_q + WCNT_W'(1);
        end else if (in_load && shift) begin
          word_buf_q  <= {word_buf_q[WORD_W-2:0], 1'b0};
          bits_left_q <= bits_left_q - BIDX_W'(1);
        end
        if (state_q == ST_FINISH && en) begin
          err_q <= verify_q && (crc_tx != crc_rx);
        end
      end
    end
  end

  cfg_crc8 u_crc_tx (
    .clk    (clk),
    .nrst   (nrst),
    .en     (tx_en),
    .clr    (start_ok),
    .bit_in (config_data_out),
    .crc    (crc_tx)
  );

  cfg_crc8 u_crc_rx (
    .clk    (clk),
    .nrst   (nrst),
    .en     (rx_en),
    .clr    (start_ok),
    .bit_in (config_data_in),
    .crc    (crc_rx)
  );

  assign busy      = (state_q != ST_IDLE);
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule
